branch_recovery_ctrl: RTL
=========================

# branch_recovery_ctrl

Sequences branch-mispredict recovery for the control-execute lane. It takes resolved control-instruction results (valid, mispredict, corrected next PC, active-list ID) from the control ALU stage and selects the oldest outstanding mispredict. It then drives a one-cycle pipeline flush, waits for the rename map-table restore, and holds a fetch redirect until fetch acknowledges it. It sits between the execute stage and the fetch, rename and active-list control logic, and stalls control-lane issue while a recovery is in flight.

## Interface
- PC_W, 32, width of PC and redirect target
- AL_W, 7, active-list index width; IDs carry one extra wrap bit (AL_W+1 bits total)
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- exeValid_i  in  1  control ALU result valid this cycle
- exeMispredict_i  in  1  mispredict flag of that result (flags bit 0); ignored when exeValid_i=0
- exeNextPC_i  in  PC_W  corrected next PC of that result
- exeAlId_i  in  AL_W+1  active-list ID of that result, MSB is the wrap bit
- alHead_i  in  AL_W+1  current active-list head (oldest instruction), same encoding
- mapRestoreDone_i  in  1  rename map-table restore complete (level, sampled in RESTORE)
- redirectAck_i  in  1  fetch accepted the redirect
- flush_o  out  1  one-cycle pulse: squash every instruction younger than flushAlId_o
- flushAlId_o  out  AL_W+1  ID of the recovering branch
- redirectValid_o  out  1  fetch redirect request
- redirectPC_o  out  PC_W  redirect target
- stallIssue_o  out  1  block control-lane issue
- recoveryCount_o  out  16  completed recoveries, saturating

## Operation
- Age: rel(x) = (x - alHead_i) mod 2^(AL_W+1). Entry a is older than b iff rel(a) < rel(b). IDs are compared at full AL_W+1 width, so wrap-around is handled.
- A candidate is exeValid_i & exeMispredict_i. Valid results without a mispredict are ignored in every state.
- Pending registers hold pendId and pendPC.
- FSM states and transitions:
  - IDLE: a candidate loads pend, next state is FLUSH.
  - FLUSH: flush_o=1 for exactly this cycle. Next state is RESTORE.
  - RESTORE: wait for mapRestoreDone_i=1, then go to REDIRECT.
  - REDIRECT: redirectValid_o=1 with redirectPC_o=pendPC, held stable until redirectAck_i=1 is sampled. On ack, recoveryCount_o increments (saturates at 0xFFFF) and the next state is IDLE.
- Preemption: in FLUSH, RESTORE or REDIRECT (including the ack cycle), a candidate strictly older than pendId replaces pend and forces the next state to FLUSH. An ack in that same cycle still counts one recovery.
  - Younger candidates are dropped, because they are on the wrong path.
  - Candidates equal to pendId are dropped as duplicates.
- A preempting candidate in the FLUSH cycle itself still takes effect; FLUSH repeats next cycle with the new ID.
- stallIssue_o = (state != IDLE).
- flushAlId_o = pendId, valid only while flush_o=1.
- All outputs are registered from state and pend; no combinational input-to-output path.

## Timing
- Reset (asynchronous, any state): state goes to IDLE, pend=0 and recoveryCount_o=0. All outputs read 0 while reset is asserted and on the first cycle after release. A recovery in progress is abandoned with no flush or redirect.
- Candidate sampled in IDLE at edge N:
  - flush_o and stallIssue_o are high in cycle N+1.
  - RESTORE starts at N+2.
  - If mapRestoreDone_i is already high at N+2, redirectValid_o rises at N+3.
- Ack sampled at edge M: redirectValid_o and stallIssue_o read 0 in cycle M+1, and the block accepts a new candidate at edge M+1.
- Minimum recovery is 4 cycles from candidate to IDLE: FLUSH, RESTORE, REDIRECT with ack in the same cycle, then IDLE.
- mapRestoreDone_i and redirectAck_i have no effect outside their own states.

## Test plan
- Single mispredict (ID 0x05, PC 0x0040_0100, head 0x00, restore done immediately, ack on the first REDIRECT cycle):
  - flush_o pulses one cycle with flushAlId_o=0x05.
  - redirectValid_o is high one cycle with redirectPC_o=0x0040_0100.
  - recoveryCount_o=1.
- Older preempt during RESTORE (pend ID 0x10, then ID 0x08 with PC 0x1000, head 0x00):
  - A second flush_o occurs with ID 0x08.
  - The redirect carries 0x1000.
  - recoveryCount_o increments by 1 only.
- Wrap-around (head 0xF0, pend 0xF8, candidate 0x02 arrives in REDIRECT): 0x02 is younger and is dropped. The redirect completes with the 0xF8 target.
- Ack back-pressure: redirectAck_i held low for 5 cycles. redirectPC_o stays stable and stallIssue_o stays high throughout; IDLE is entered the cycle after the ack.
- Reset mid-REDIRECT: reset asserted asynchronously between edges drops all outputs to 0 at once. No redirect is issued after release and recoveryCount_o=0.
- Saturation: with the counter preset to 0xFFFE by driving two recoveries past that point, recoveryCount_o holds at 0xFFFF.

Source files
------------

// File: rtl/branch_recovery_ctrl.sv
// Branch-mispredict recovery sequencer for the control-execute lane.
// Tracks the oldest outstanding mispredict and walks it through flush,
// map-table restore and fetch redirect, stalling control-lane issue meanwhile.
//
// state       | meaning
// ------------+---------------------------------------------------------
// ST_IDLE     | no recovery in flight, waiting for a mispredict
// ST_FLUSH    | one-cycle squash of everything younger than pend_id
// ST_RESTORE  | waiting for the rename map table to finish restoring
// ST_REDIRECT | redirect to pend_pc held until fetch acknowledges
module branch_recovery_ctrl #(
  parameter int PC_W = 32,
  parameter int AL_W = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              exeValid_i,
  input  logic              exeMispredict_i,
  input  logic [PC_W-1:0]   exeNextPC_i,
  input  logic [AL_W:0]     exeAlId_i,
  input  logic [AL_W:0]     alHead_i,
  input  logic              mapRestoreDone_i,
  input  logic              redirectAck_i,
  output logic              flush_o,
  output logic [AL_W:0]     flushAlId_o,
  output logic              redirectValid_o,
  output logic [PC_W-1:0]   redirectPC_o,
  output logic              stallIssue_o,
  output logic [15:0]       recoveryCount_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_RESTORE,
    ST_REDIRECT
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [AL_W:0]     pend_id;
  logic [AL_W:0]     pend_id_nxt;
  logic [PC_W-1:0]   pend_pc;
  logic [PC_W-1:0]   pend_pc_nxt;
  logic [15:0]       rec_count;
  logic [15:0]       rec_count_nxt;
  logic [AL_W:0]     rel_cand;
  logic [AL_W:0]     rel_pend;
  logic              cand;
  logic              cand_older;

  // Age is distance from the active-list head, modulo the full ID width
  // including the wrap bit, so wrapped IDs order correctly.
  assign cand       = exeValid_i & exeMispredict_i;
  assign rel_cand   = exeAlId_i - alHead_i;
  assign rel_pend   = pend_id - alHead_i;
  assign cand_older = (rel_cand < rel_pend);

  assign recoveryCount_o = rec_count;

  // Next-state, pending-branch and counter update.
  always_comb begin
    state_nxt     = state;
    pend_id_nxt   = pend_id;
    pend_pc_nxt   = pend_pc;
    rec_count_nxt = rec_count;
    case (state)
      ST_IDLE: begin
        if (cand) begin
          pend_id_nxt = exeAlId_i;
          pend_pc_nxt = exeNextPC_i;
          state_nxt   = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        state_nxt = ST_RESTORE;
      end
      ST_RESTORE: begin
        if (mapRestoreDone_i) begin
          state_nxt = ST_REDIRECT;
        end
      end
      ST_REDIRECT: begin
        if (redirectAck_i) begin
          state_nxt = ST_IDLE;
          if (rec_count != 16'hFFFF) begin
            rec_count_nxt = rec_count + 16'd1;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    // An older mispredict overrides whatever the current recovery was doing;
    // younger or duplicate ones are on the squashed path and are dropped.
    if ((state != ST_IDLE) && cand && cand_older) begin
      pend_id_nxt = exeAlId_i;
      pend_pc_nxt = exeNextPC_i;
      state_nxt   = ST_FLUSH;
    end
  end

  // State, pending branch and registered outputs decoded from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= ST_IDLE;
      pend_id         <= '0;
      pend_pc         <= '0;
      rec_count       <= '0;
      flush_o         <= 1'b0;
      flushAlId_o     <= '0;
      redirectValid_o <= 1'b0;
      redirectPC_o    <= '0;
      stallIssue_o    <= 1'b0;
    end else begin
      state           <= state_nxt;
      pend_id         <= pend_id_nxt;
      pend_pc         <= pend_pc_nxt;
      rec_count       <= rec_count_nxt;
      flush_o         <= (state_nxt == ST_FLUSH);
      flushAlId_o     <= (state_nxt == ST_FLUSH) ? pend_id_nxt : '0;
      redirectValid_o <= (state_nxt == ST_REDIRECT);
      redirectPC_o    <= (state_nxt == ST_REDIRECT) ? pend_pc_nxt : '0;
      stallIssue_o    <= (state_nxt != ST_IDLE);
    end
  end

endmodule
